proc_ctrl_fsm: RTL and testbench

Multi-cycle control unit for the 8-bit accumulator processor inside `tt_um_myprocessor`. It owns the program counter and the instruction/operand registers, and sequences fetch, operand fetch, data access and execute over a single shared memory port. It drives the ALU opcode and the accumulator load strobe into the datapath, so the datapath itself holds no control state.

---
 rtl/proc_pkg.sv | 34 +++
 rtl/proc_decode.sv | 68 ++++++
 rtl/proc_ctrl_fsm.sv | 138 +++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the accumulator-processor control unit:
// opcode values, ALU operation encodings and the controller state enum.
package proc_pkg;

  // Instruction opcodes, held in ir[7:4]
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation encodings driven into the datapath
  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_OPER,
    ST_DATA,
    ST_EXEC
  } state_e;

endpackage

// File: rtl/proc_decode.sv
// Purely combinational instruction decoder: classifies an opcode into the
// handful of attributes the sequencer needs.
module proc_decode
  import proc_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       needs_operand,
  output logic       needs_data,
  output logic       is_store,
  output logic [2:0] alu_op,
  output logic       is_load,
  output logic       is_jump,
  output logic       is_cond,
  output logic       is_halt,
  output logic       is_illegal
);

  // Opcode classification; NOP falls through with every flag low
  always_comb begin
    needs_operand = 1'b0;
    needs_data    = 1'b0;
    is_store      = 1'b0;
    alu_op        = ALU_ADD;
    is_load       = 1'b0;
    is_jump       = 1'b0;
    is_cond       = 1'b0;
    is_halt       = 1'b0;
    is_illegal    = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_LDI: begin
        needs_operand = 1'b1;
        is_load       = 1'b1;
        alu_op        = ALU_PASS_B;
      end
      OP_LDA: begin
        needs_operand = 1'b1;
        needs_data    = 1'b1;
        is_load       = 1'b1;
        alu_op        = ALU_PASS_B;
      end
      OP_STA: begin
        needs_operand = 1'b1;
        needs_data    = 1'b1;
        is_store      = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        needs_operand = 1'b1;
        needs_data    = 1'b1;
        is_load       = 1'b1;
        // ADD..OR map onto ALU codes 0..3 in opcode order
        alu_op        = {1'b0, opcode[1:0]};
      end
      OP_JMP: begin
        needs_operand = 1'b1;
        is_jump       = 1'b1;
      end
      OP_JZ: begin
        needs_operand = 1'b1;
        is_jump       = 1'b1;
        is_cond       = 1'b1;
      end
      OP_HLT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit: owns PC/IR/operand/data registers and sequences
// fetch, operand fetch, data access and execute over one memory port.
// Outputs depend only on state and registers, never on mem_ready.
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  input  logic       acc_zero,
  output logic [2:0] alu_op,
  output logic       acc_load,
  output logic [7:0] operand,
  output logic [7:0] pc,
  output logic       halted,
  output logic       illegal
);

  state_e     state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] ir_reg, ir_next;
  logic [7:0] opr_reg, opr_next;
  logic [7:0] mdr_reg, mdr_next;
  logic       illegal_reg, illegal_next;

  logic       dec_needs_operand, dec_needs_data, dec_is_store, dec_is_load;
  logic       dec_is_jump, dec_is_cond, dec_is_halt, dec_is_illegal;
  logic [2:0] dec_alu_op;

  // Low opcode nibble carries no meaning in this ISA
  logic       unused_ir_low;
  assign unused_ir_low = ^ir_reg[3:0];

  proc_decode u_decode (
    .opcode        (ir_reg[7:4]),
    .needs_operand (dec_needs_operand),
    .needs_data    (dec_needs_data),
    .is_store      (dec_is_store),
    .alu_op        (dec_alu_op),
    .is_load       (dec_is_load),
    .is_jump       (dec_is_jump),
    .is_cond       (dec_is_cond),
    .is_halt       (dec_is_halt),
    .is_illegal    (dec_is_illegal)
  );

  // State and architectural registers; reset returns everything to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= RESET_PC;
      ir_reg      <= 8'h00;
      opr_reg     <= 8'h00;
      mdr_reg     <= 8'h00;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      opr_reg     <= opr_next;
      mdr_reg     <= mdr_next;
      illegal_reg <= illegal_next;
    end
  end

  // Next-state, register updates and decoded outputs
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    opr_next     = opr_reg;
    mdr_next     = mdr_reg;
    illegal_next = illegal_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = pc_reg;
    alu_op       = ALU_ADD;
    acc_load     = 1'b0;
    operand      = 8'h00;
    case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_next    = mem_rdata;
          pc_next    = pc_reg + 8'd1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = dec_needs_operand ? ST_OPER : ST_EXEC;
      end
      ST_OPER: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          opr_next   = mem_rdata;
          pc_next    = pc_reg + 8'd1;
          state_next = dec_needs_data ? ST_DATA : ST_EXEC;
        end
      end
      ST_DATA: begin
        mem_req  = 1'b1;
        mem_we   = dec_is_store;
        mem_addr = opr_reg;
        if (mem_ready) begin
          if (!dec_is_store) mdr_next = mem_rdata;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_is_load) begin
          acc_load = 1'b1;
          alu_op   = dec_alu_op;
          // LDI is the only load whose B input is the immediate byte
          operand  = (ir_reg[7:4] == OP_LDI) ? opr_reg : mdr_reg;
        end
        if (dec_is_jump && (!dec_is_cond || acc_zero)) pc_next = opr_reg;
        if (dec_is_illegal) illegal_next = 1'b1;
        state_next = (dec_is_halt || dec_is_illegal) ? ST_IDLE : ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pc      = pc_reg;
  assign halted  = (state_reg == ST_IDLE);
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: memory with configurable wait states, a small
// accumulator model, table-driven program runs and hand-written sequences.
// The DUT boots at FE where every image holds "JMP 00", so each program run
// also exercises the PC wrap from FF to 00.
module tb_proc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       mem_req, mem_we, mem_ready, acc_zero, acc_load, halted, illegal;
  logic [7:0] mem_addr, mem_rdata, operand, pc;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  proc_ctrl_fsm #(.RESET_PC(8'hFE)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .acc_zero(acc_zero),
    .alu_op(alu_op), .acc_load(acc_load), .operand(operand),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  // ---------------- environment model ----------------
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] acc;
  logic       clr = 1'b0;
  logic       force_nz = 1'b0;
  int         wait_n = 0;
  int         wait_cnt;
  int         n_loads, n_wr, cycles, req_cycles, viol;
  logic [2:0] ev_op [4];
  logic [7:0] ev_opd [4];
  logic [7:0] wr_addr;
  logic       prev_wait;
  logic [7:0] prev_addr;

  assign mem_ready = mem_req && (wait_cnt == wait_n);
  assign mem_rdata = mem[mem_addr];
  assign acc_zero  = force_nz ? 1'b0 : (acc == 8'h00);

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return b;
    endcase
  endfunction

  // Wait-state counter: counts ready-low cycles of the pending access
  always @(posedge clk) begin
    if (rst || !mem_req || mem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Datapath/memory model and event log, sampled mid-cycle
  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      acc <= 8'h00;
      n_loads <= 0; n_wr <= 0; cycles <= 0; req_cycles <= 0; viol <= 0;
      wr_addr <= 8'h00; prev_wait <= 1'b0; prev_addr <= 8'h00;
      for (int i = 0; i < 4; i++) begin ev_op[i] <= 3'd0; ev_opd[i] <= 8'h00; end
    end else begin
      if (acc_load) begin
        acc <= alu(alu_op, acc, operand);
        if (n_loads < 4) begin ev_op[n_loads] <= alu_op; ev_opd[n_loads] <= operand; end
        n_loads <= n_loads + 1;
      end
      if (mem_req && mem_we && mem_ready) begin
        mem[mem_addr] <= acc;
        wr_addr <= mem_addr;
        n_wr <= n_wr + 1;
      end
      if (!halted) cycles <= cycles + 1;
      if (mem_req) req_cycles <= req_cycles + 1;
      if (prev_wait && (!mem_req || mem_addr != prev_addr)) viol <= viol + 1;
      prev_wait <= mem_req && !mem_ready;
      prev_addr <= mem_addr;
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [0:7][7:0] prog;
    logic [7:0]      b10, b20;
    int              wait_n;
    bit              force_nz;
    logic [7:0]      exp_pc;
    bit              exp_ill;
    logic [7:0]      exp_acc, exp_m11;
    int              exp_nloads;
    logic [2:0]      exp_op0, exp_op1;
    logic [7:0]      exp_opd0, exp_opd1;
    int              exp_nwr;
    logic [7:0]      exp_wr_addr;
    int              exp_cycles, exp_req;
  } vec_t;

  vec_t vecs [5];

  task automatic load_image(input vec_t v);
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    for (int i = 0; i < 8; i++) img[i] = v.prog[i];
    img[8'h10] = v.b10;
    img[8'h20] = v.b20;
    img[8'hFE] = 8'h80;
    img[8'hFF] = 8'h00;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); @(negedge clk); clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_halt();
    for (int k = 0; k < 600 && !halted; k++) @(negedge clk);
  endtask

  logic [0:7][7:0] main_prog;
  logic [0:7][7:0] jz_prog;
  logic [0:7][7:0] ill_prog;
  bit seen;

  initial begin
    main_prog = {8'h10, 8'h05, 8'h40, 8'h10, 8'h30, 8'h11, 8'hF0, 8'h00};
    jz_prog   = {8'h90, 8'h20, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ill_prog  = {8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    // prog, b10, b20, wait, nz, pc, ill, acc, m11, nloads, op0, op1, opd0, opd1, nwr, wraddr, cycles, reqs
    vecs[0] = '{main_prog, 8'h03, 8'h00, 0, 0, 8'h07, 0, 8'h08, 8'h08, 2, 3'd4, 3'd0, 8'h05, 8'h03, 1, 8'h11, 21, 11};
    vecs[1] = '{main_prog, 8'h03, 8'h00, 2, 0, 8'h07, 0, 8'h08, 8'h08, 2, 3'd4, 3'd0, 8'h05, 8'h03, 1, 8'h11, 43, 33};
    vecs[2] = '{jz_prog,   8'h00, 8'hF0, 0, 0, 8'h21, 0, 8'h00, 8'h00, 0, 3'd0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 11, 5};
    vecs[3] = '{jz_prog,   8'h00, 8'hF0, 0, 1, 8'h03, 0, 8'h00, 8'h00, 0, 3'd0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 11, 5};
    vecs[4] = '{ill_prog,  8'h00, 8'h00, 0, 0, 8'h01, 1, 8'h00, 8'h00, 0, 3'd0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 7, 3};

    // Reset state
    do_reset();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 8'hFE);
    check("rst_alu_op", alu_op, 0);
    check("rst_operand", operand, 0);
    check("rst_acc_load", acc_load, 0);
    check("rst_pc", pc, 8'hFE);
    check("rst_halted", halted, 1);
    check("rst_illegal", illegal, 0);

    // PC wrap: fetch FE, operand at FF leaves pc=00, JMP 00 keeps 00
    wait_n = 0;
    load_image(vecs[0]);
    do_reset();
    pulse_run();
    check("wrap_fetch_addr", mem_addr, 8'hFE);
    check("wrap_fetch_req", mem_req, 1);
    @(negedge clk);
    check("wrap_decode_pc", pc, 8'hFF);
    check("wrap_decode_req", mem_req, 0);
    @(negedge clk);
    check("wrap_oper_addr", mem_addr, 8'hFF);
    check("wrap_oper_req", mem_req, 1);
    @(negedge clk);
    check("wrap_exec_pc", pc, 8'h00);
    @(negedge clk);
    check("wrap_refetch_addr", mem_addr, 8'h00);
    check("wrap_refetch_req", mem_req, 1);
    wait_halt();
    $display("wrap sequence: pc=%h halted=%0d", pc, halted);

    // Table-driven program runs
    for (int r = 0; r < 5; r++) begin
      wait_n   = vecs[r].wait_n;
      force_nz = vecs[r].force_nz;
      load_image(vecs[r]);
      do_reset();
      pulse_run();
      wait_halt();
      @(negedge clk);
      check($sformatf("row%0d_halted", r), halted, 1);
      check($sformatf("row%0d_pc", r), pc, vecs[r].exp_pc);
      check($sformatf("row%0d_illegal", r), illegal, vecs[r].exp_ill);
      check($sformatf("row%0d_acc", r), acc, vecs[r].exp_acc);
      check($sformatf("row%0d_mem11", r), mem[8'h11], vecs[r].exp_m11);
      check($sformatf("row%0d_nloads", r), n_loads, vecs[r].exp_nloads);
      check($sformatf("row%0d_load0_op", r), ev_op[0], vecs[r].exp_op0);
      check($sformatf("row%0d_load0_opd", r), ev_opd[0], vecs[r].exp_opd0);
      check($sformatf("row%0d_load1_op", r), ev_op[1], vecs[r].exp_op1);
      check($sformatf("row%0d_load1_opd", r), ev_opd[1], vecs[r].exp_opd1);
      check($sformatf("row%0d_nwrites", r), n_wr, vecs[r].exp_nwr);
      check($sformatf("row%0d_wr_addr", r), wr_addr, vecs[r].exp_wr_addr);
      check($sformatf("row%0d_cycles", r), cycles, vecs[r].exp_cycles);
      check($sformatf("row%0d_req_cycles", r), req_cycles, vecs[r].exp_req);
      check($sformatf("row%0d_addr_stable", r), viol, 0);
      $display("row %0d: wait=%0d pc=%h acc=%h ill=%0d loads=%0d writes=%0d cycles=%0d",
               r, wait_n, pc, acc, illegal, n_loads, n_wr, cycles);
    end

    // Illegal flag persists across a later run
    check("ill_before_run", illegal, 1);
    pulse_run();
    check("ill_resume_running", halted, 0);
    check("ill_persists", illegal, 1);
    $display("illegal persistence: halted=%0d illegal=%0d", halted, illegal);

    // Reset during the data phase of STA, with run asserted alongside
    wait_n   = 2;
    force_nz = 1'b0;
    load_image(vecs[1]);
    do_reset();
    pulse_run();
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (mem_req && mem_we) seen = 1'b1;
      else @(negedge clk);
    end
    check("sta_data_reached", seen, 1);
    check("sta_data_addr", mem_addr, 8'h11);
    rst = 1'b1;
    run = 1'b1;
    @(negedge clk);
    check("strst_mem_req", mem_req, 0);
    check("strst_mem_we", mem_we, 0);
    check("strst_acc_load", acc_load, 0);
    check("strst_halted", halted, 1);
    check("strst_pc", pc, 8'hFE);
    check("strst_mem_addr", mem_addr, 8'hFE);
    check("strst_operand", operand, 0);
    check("strst_alu_op", alu_op, 0);
    rst = 1'b0;
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("strst_stays_idle", halted, 1);
    check("strst_no_req", mem_req, 0);
    check("strst_mem11", mem[8'h11], 8'h00);
    check("strst_nloads", n_loads, 2);
    pulse_run();
    check("strst_restart_req", mem_req, 1);
    check("strst_restart_addr", mem_addr, 8'hFE);
    $display("reset in STA data phase: mem11=%h loads=%0d", mem[8'h11], n_loads);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
